// File: rtl/test_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_arb_pkg
// Description : Shared constants and FSM state encoding for the two-port
//               read/write test arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package test_arb_pkg;

    localparam int c_NUM_PORTS = 2;
    localparam int c_LEN_W     = 4;
    localparam int c_ID_W      = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        WR   = 3'd2,
        RD   = 3'd3,
        DONE = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/test_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : test_rr_arb2
// Description : Two-requester round-robin selector; a tie goes to the port
//               that was not served last.
// Revision    : 1.0 - initial release
// ============================================================================
module test_rr_arb2
    import test_arb_pkg::*;
(
    input  logic [c_NUM_PORTS-1:0] req,
    input  logic                   last_grant,
    output logic                   grant_valid,
    output logic                   grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/test_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : test_rw_arbiter
// Description : Round-robin arbiter issuing one read or write command at a
//               time from two requesters to the DDR read/write engines.
//               Optional watchdog enabled by defining TEST_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module test_rw_arbiter
    import test_arb_pkg::*;
#(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int TIMEOUT_CYCLES  = 4096
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ddrc_init_done,
    input  logic [c_NUM_PORTS-1:0]     req,
    input  logic [c_NUM_PORTS-1:0]     req_wr,
    input  logic [CTRL_ADDR_WIDTH-1:0] req_addr0,
    input  logic [CTRL_ADDR_WIDTH-1:0] req_addr1,
    input  logic [c_LEN_W-1:0]         req_len0,
    input  logic [c_LEN_W-1:0]         req_len1,
    input  logic [c_ID_W-1:0]          req_id0,
    input  logic [c_ID_W-1:0]          req_id1,
    output logic [c_NUM_PORTS-1:0]     ack,
    output logic                       ack_err,
    output logic [CTRL_ADDR_WIDTH-1:0] rw_addr,
    output logic [c_LEN_W-1:0]         rw_len,
    output logic [c_ID_W-1:0]          rw_id,
    output logic                       write_en,
    output logic                       read_en,
    input  logic                       write_done_p,
    input  logic                       read_done_p,
    output logic [15:0]                op_cnt,
    output logic                       timeout_err
);

    arb_state_t r_state;
    logic       r_grant;
    logic       r_last_grant;
    logic       r_init_meta;
    logic       r_init_sync;
    logic       w_grant_valid;
    logic       w_grant_idx;
    logic       w_done;
    logic       w_tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_meta <= 1'b0;
            r_init_sync <= 1'b0;
        end else begin
            r_init_meta <= ddrc_init_done;
            r_init_sync <= r_init_meta;
        end
    end

    test_rr_arb2 u_rr_arb (
        .req         (req),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Only the engine matching the active direction may complete the command.
    assign w_done = ((r_state == WR) && write_done_p) ||
                    ((r_state == RD) && read_done_p);

`ifdef TEST_ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ARB) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == WR) || (r_state == RD)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo_cfg;

    assign w_tmo_hit        = 1'b0;
    assign w_unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign ack_err          = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            write_en     <= 1'b0;
            read_en      <= 1'b0;
            ack          <= '0;
            rw_addr      <= '0;
            rw_len       <= '0;
            rw_id        <= '0;
            op_cnt       <= '0;
`ifdef TEST_ARB_TIMEOUT_EN
            ack_err      <= 1'b0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef TEST_ARB_TIMEOUT_EN
            ack_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (r_init_sync) begin
                        r_state <= ARB;
                    end
                end

                ARB: begin
                    if (w_grant_valid) begin
                        r_grant <= w_grant_idx;
                        rw_addr <= w_grant_idx ? req_addr1 : req_addr0;
                        rw_len  <= w_grant_idx ? req_len1  : req_len0;
                        rw_id   <= w_grant_idx ? req_id1   : req_id0;
                        if (req_wr[w_grant_idx]) begin
                            write_en <= 1'b1;
                            r_state  <= WR;
                        end else begin
                            read_en <= 1'b1;
                            r_state <= RD;
                        end
                    end
                end

                WR, RD: begin
                    if (w_done) begin
                        write_en <= 1'b0;
                        read_en  <= 1'b0;
                        ack      <= r_grant ? 2'b10 : 2'b01;
                        r_state  <= DONE;
                    end else if (w_tmo_hit) begin
                        write_en <= 1'b0;
                        read_en  <= 1'b0;
                        ack      <= r_grant ? 2'b10 : 2'b01;
                        r_state  <= DONE;
`ifdef TEST_ARB_TIMEOUT_EN
                        ack_err     <= 1'b1;
                        timeout_err <= 1'b1;
`endif
                    end
                end

                DONE: begin
                    r_last_grant <= r_grant;
                    if (op_cnt != 16'hFFFF) begin
                        op_cnt <= op_cnt + 16'd1;
                    end
                    r_state <= r_init_sync ? ARB : IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_test_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_rw_arbiter
// Description : Self-checking bench for test_rw_arbiter: vector table, corner
//               sequences and a randomized run against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_rw_arbiter;

    localparam int AW = 28;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ddrc_init_done = 1'b0;
    logic [1:0]    req = '0;
    logic [1:0]    req_wr = '0;
    logic [AW-1:0] req_addr0 = '0, req_addr1 = '0;
    logic [3:0]    req_len0 = '0, req_len1 = '0;
    logic [3:0]    req_id0 = '0, req_id1 = '0;
    logic [1:0]    ack;
    logic          ack_err;
    logic [AW-1:0] rw_addr;
    logic [3:0]    rw_len;
    logic [3:0]    rw_id;
    logic          write_en, read_en;
    logic          write_done_p = 1'b0, read_done_p = 1'b0;
    logic [15:0]   op_cnt;
    logic          timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ops    = 0;

    test_rw_arbiter #(
        .CTRL_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ddrc_init_done (ddrc_init_done),
        .req            (req),
        .req_wr         (req_wr),
        .req_addr0      (req_addr0),
        .req_addr1      (req_addr1),
        .req_len0       (req_len0),
        .req_len1       (req_len1),
        .req_id0        (req_id0),
        .req_id1        (req_id1),
        .ack            (ack),
        .ack_err        (ack_err),
        .rw_addr        (rw_addr),
        .rw_len         (rw_len),
        .rw_id          (rw_id),
        .write_en       (write_en),
        .read_en        (read_en),
        .write_done_p   (write_done_p),
        .read_done_p    (read_done_p),
        .op_cnt         (op_cnt),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    mask;
        logic [1:0]    wr;
        int            delay;
        bit            stray;
        bit            first;
        logic [AW-1:0] addr;
        logic [3:0]    len;
        logic [3:0]    id;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_cmd(input bit p, input logic wr, input logic [AW-1:0] a,
                           input logic [3:0] l, input logic [3:0] i);
        if (p) begin
            req_addr1 = a; req_len1 = l; req_id1 = i;
        end else begin
            req_addr0 = a; req_len0 = l; req_id0 = i;
        end
        req_wr[p] = wr;
        req[p]    = 1'b1;
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (write_en || read_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Serve one command from port p: enable must last exactly `delay` cycles.
    task automatic serve(input bit p, input int delay, input bit stray, input bit seen);
        bit            ok;
        logic [AW-1:0] ea;
        logic [3:0]    el, ei;
        logic          ew;
        ea = p ? req_addr1 : req_addr0;
        el = p ? req_len1 : req_len0;
        ei = p ? req_id1 : req_id0;
        ew = req_wr[p];
        ok = seen;
        if (!seen) wait_en(ok);
        check("grant_seen", 32'(ok), 32'd1);
        if (!ok) return;
        check("grant_addr", 32'(rw_addr), 32'(ea));
        check("grant_len", 32'(rw_len), 32'(el));
        check("grant_id", 32'(rw_id), 32'(ei));
        check("grant_dir", 32'({write_en, read_en}), ew ? 32'd2 : 32'd1);
        for (int c = 1; c < delay; c++) begin
            if (stray && c == 1) begin
                if (ew) read_done_p = 1'b1;
                else    write_done_p = 1'b1;
            end
            @(negedge clk);
            write_done_p = 1'b0;
            read_done_p  = 1'b0;
            check("en_hold", 32'({write_en, read_en}), ew ? 32'd2 : 32'd1);
            check("cmd_hold", 32'(rw_addr), 32'(ea));
            check("no_early_ack", 32'(ack), 32'd0);
        end
        if (ew) write_done_p = 1'b1;
        else    read_done_p = 1'b1;
        @(negedge clk);
        write_done_p = 1'b0;
        read_done_p  = 1'b0;
        check("en_drop", 32'({write_en, read_en}), 32'd0);
        check("ack", 32'(ack), p ? 32'd2 : 32'd1);
        check("ack_err", 32'(ack_err), 32'd0);
        req[p] = 1'b0;
        m_ops++;
        @(negedge clk);
        check("ack_pulse", 32'(ack), 32'd0);
        check("op_cnt", 32'(op_cnt), 32'(m_ops));
    endtask

    task automatic do_reset(input logic init);
        rst_n = 1'b0;
        req = '0;
        write_done_p = 1'b0;
        read_done_p = 1'b0;
        ddrc_init_done = init;
        m_ops = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bit            ok;
        int            cnt, lat, n_hi;
        bit            act, done_sent, ap, aw, ep;
        logic [AW-1:0] a_addr;
        logic [3:0]    a_len, a_id;
        int            wait_left;
        bit            m_lg;
        logic [AW-1:0] ra;

        vecs[0] = '{mask:2'b01, wr:2'b01, delay:10, stray:1'b0, first:1'b0, addr:28'h0000080, len:4'd3, id:4'd5};
        vecs[1] = '{mask:2'b11, wr:2'b11, delay:3,  stray:1'b0, first:1'b1, addr:28'h0001000, len:4'd1, id:4'd2};
        vecs[2] = '{mask:2'b11, wr:2'b00, delay:2,  stray:1'b0, first:1'b1, addr:28'h0002000, len:4'd7, id:4'd0};
        vecs[3] = '{mask:2'b11, wr:2'b10, delay:1,  stray:1'b0, first:1'b1, addr:28'h0003000, len:4'd2, id:4'd9};
        vecs[4] = '{mask:2'b11, wr:2'b01, delay:5,  stray:1'b1, first:1'b1, addr:28'h0004000, len:4'd4, id:4'd3};
        vecs[5] = '{mask:2'b10, wr:2'b00, delay:4,  stray:1'b1, first:1'b1, addr:28'h0005000, len:4'd6, id:4'd8};
        vecs[6] = '{mask:2'b11, wr:2'b11, delay:2,  stray:1'b0, first:1'b0, addr:28'h0006000, len:4'd0, id:4'd1};
        vecs[7] = '{mask:2'b01, wr:2'b00, delay:1,  stray:1'b0, first:1'b0, addr:28'h0007000, len:4'd15, id:4'd14};
        vecs[8] = '{mask:2'b10, wr:2'b10, delay:1,  stray:1'b0, first:1'b1, addr:28'h0008000, len:4'd8, id:4'd4};
        vecs[9] = '{mask:2'b11, wr:2'b01, delay:3,  stray:1'b0, first:1'b0, addr:28'h0009000, len:4'd5, id:4'd6};

        // Reset state, sampled while reset is held.
        rst_n = 1'b0;
        ddrc_init_done = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_read_en", 32'(read_en), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_rw_addr", 32'(rw_addr), 32'd0);
        check("rst_rw_len", 32'(rw_len), 32'd0);
        check("rst_rw_id", 32'(rw_id), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        do_reset(1'b1);
        repeat (4) @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            for (int p = 0; p < 2; p++) begin
                if (vecs[v].mask[p]) begin
                    set_cmd(p[0], vecs[v].wr[p], vecs[v].addr + AW'(p * 256),
                            p[0] ? ~vecs[v].len : vecs[v].len, vecs[v].id + 4'(p));
                end
            end
            serve(vecs[v].first, vecs[v].delay, vecs[v].stray, 1'b0);
            if (vecs[v].mask == 2'b11) serve(!vecs[v].first, vecs[v].delay, vecs[v].stray, 1'b0);
        end

        // Init done held low, rises later: two sync flops, IDLE->ARB, grant.
        do_reset(1'b0);
        set_cmd(1'b0, 1'b1, 28'h0000abc, 4'd2, 4'd7);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (write_en || read_en) cnt++;
        end
        check("init_low_no_enable", 32'(cnt), 32'd0);
        ddrc_init_done = 1'b1;
        lat = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (write_en || read_en) begin
                lat = k;
                break;
            end
        end
        check("init_rise_latency", 32'(lat), 32'd4);
        // Init drops mid-operation: the op completes, then no new grant.
        ddrc_init_done = 1'b0;
        serve(1'b0, 3, 1'b0, lat != 0);
        set_cmd(1'b1, 1'b0, 28'h0000def, 4'd1, 4'd3);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (write_en || read_en) cnt++;
        end
        check("init_fall_idle", 32'(cnt), 32'd0);
        ddrc_init_done = 1'b1;
        serve(1'b1, 2, 1'b0, 1'b0);

        // Reset during a write.
        set_cmd(1'b0, 1'b1, 28'h0000123, 4'd4, 4'd4);
        wait_en(ok);
        check("rst_mid_grant", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_write_en", 32'(write_en), 32'd0);
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_op_cnt", 32'(op_cnt), 32'd0);
        req = '0;
        m_ops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (write_en || read_en || ack != 2'b00) cnt++;
        end
        check("rst_mid_quiet", 32'(cnt), 32'd0);
        set_cmd(1'b0, 1'b0, 28'h0000200, 4'd9, 4'd1);
        set_cmd(1'b1, 1'b1, 28'h0000300, 4'd10, 4'd2);
        serve(1'b0, 2, 1'b0, 1'b0);
        serve(1'b1, 2, 1'b0, 1'b0);

`ifdef TEST_ARB_TIMEOUT_EN
        set_cmd(1'b0, 1'b1, 28'h0001234, 4'd1, 4'd1);
        wait_en(ok);
        check("tmo_grant", 32'(ok), 32'd1);
        n_hi = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!(write_en || read_en)) break;
            n_hi++;
        end
        check("tmo_len", 32'(n_hi), 32'd16);
        check("tmo_ack", 32'(ack), 32'd1);
        check("tmo_ack_err", 32'(ack_err), 32'd1);
        check("tmo_flag", 32'(timeout_err), 32'd1);
        req[0] = 1'b0;
        m_ops++;
        @(negedge clk);
        check("tmo_ack_err_pulse", 32'(ack_err), 32'd0);
        check("tmo_op_cnt", 32'(op_cnt), 32'(m_ops));
        set_cmd(1'b1, 1'b0, 28'h0005678, 4'd2, 4'd2);
        serve(1'b1, 2, 1'b0, 1'b0);
        check("tmo_flag_sticky", 32'(timeout_err), 32'd1);
`else
        n_hi = 0;
        check("no_tmo_flag", 32'(timeout_err), 32'(n_hi));
`endif

        // Randomized traffic against a transaction-level model.
        do_reset(1'b1);
        m_lg = 1'b1;
        act = 1'b0;
        done_sent = 1'b0;
        ap = 1'b0;
        aw = 1'b0;
        a_addr = '0;
        a_len = '0;
        a_id = '0;
        wait_left = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            write_done_p = 1'b0;
            read_done_p  = 1'b0;
            check("rnd_op_cnt", 32'(op_cnt), 32'(m_ops));
            check("rnd_en_excl", 32'(write_en & read_en), 32'd0);
            check("rnd_timeout_err", 32'(timeout_err), 32'd0);
            if (done_sent) begin
                check("rnd_ack", 32'(ack), ap ? 32'd2 : 32'd1);
                check("rnd_ack_err", 32'(ack_err), 32'd0);
                check("rnd_en_drop", 32'({write_en, read_en}), 32'd0);
                m_lg = ap;
                m_ops++;
                act = 1'b0;
                done_sent = 1'b0;
                req[ap] = 1'b0;
            end else begin
                check("rnd_no_ack", 32'(ack), 32'd0);
                if (!act && (write_en || read_en)) begin
                    ep = (req == 2'b11) ? !m_lg : req[1];
                    check("rnd_grant_has_req", 32'(req[ep]), 32'd1);
                    ap = ep;
                    aw = req_wr[ep];
                    a_addr = ep ? req_addr1 : req_addr0;
                    a_len = ep ? req_len1 : req_len0;
                    a_id = ep ? req_id1 : req_id0;
                    check("rnd_grant_len", 32'(rw_len), 32'(a_len));
                    check("rnd_grant_id", 32'(rw_id), 32'(a_id));
                    act = 1'b1;
                    wait_left = $urandom_range(1, 8);
                end
                if (act) begin
                    check("rnd_en", 32'({write_en, read_en}), aw ? 32'd2 : 32'd1);
                    check("rnd_addr", 32'(rw_addr), 32'(a_addr));
                    wait_left--;
                    if (wait_left == 0) begin
                        if (aw) write_done_p = 1'b1;
                        else    read_done_p = 1'b1;
                        done_sent = 1'b1;
                    end else if ($urandom_range(0, 4) == 0) begin
                        if (aw) read_done_p = 1'b1;
                        else    write_done_p = 1'b1;
                    end
                end else if ($urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 1) == 0) write_done_p = 1'b1;
                    else                           read_done_p = 1'b1;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!req[p] && $urandom_range(0, 3) == 0) begin
                    ra = AW'($urandom);
                    ra[0] = p[0];
                    set_cmd(p[0], 1'($urandom_range(0, 1)), ra,
                            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                end
            end
        end
        write_done_p = 1'b0;
        read_done_p  = 1'b0;
        check("rnd_progress", 32'(m_ops > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
